// File: rtl/vga_mem_arbiter.sv
// Frame-buffer BRAM port arbiter: display reads vs host writes, fixed read latency.
// Optional host starvation guard enabled by defining VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arbiter #(
    parameter int MEM_WIDTH      = 24,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int RD_LATENCY     = 1,
    parameter int STARVE_MAX     = 8
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      disp_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] disp_addr_i,
    output logic                      disp_gnt_o,
    output logic                      disp_valid_o,
    output logic [MEM_WIDTH-1:0]      disp_data_o,
    input  logic                      wr_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [MEM_WIDTH-1:0]      wr_data_i,
    output logic                      wr_gnt_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_WIDTH-1:0]      mem_din_o,
    input  logic [MEM_WIDTH-1:0]      mem_dout_i
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DISP_ACC = 2'd1;
    localparam logic [1:0] HOST_ACC = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  host_force;
    logic [RD_LATENCY-1:0] rd_pipe;

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;

    assign host_force = wr_req_i && (starve_cnt == CW'(STARVE_MAX));

    // Counts display wins taken while the host is waiting.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt <= '0;
        end else if (!wr_req_i || state == HOST_ACC) begin
            starve_cnt <= '0;
        end else if (state == IDLE && state_nxt == DISP_ACC) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign host_force = 1'b0;
`endif

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) begin
            if (host_force) begin
                state_nxt = HOST_ACC;
            end else if (disp_req_i) begin
                state_nxt = DISP_ACC;
            end else if (wr_req_i) begin
                state_nxt = HOST_ACC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_din_o  <= '0;
            disp_gnt_o <= 1'b0;
            wr_gnt_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_en_o   <= (state_nxt != IDLE);
            mem_we_o   <= (state_nxt == HOST_ACC);
            disp_gnt_o <= (state_nxt == DISP_ACC);
            wr_gnt_o   <= (state_nxt == HOST_ACC);
            if (state_nxt == DISP_ACC) begin
                mem_addr_o <= disp_addr_i;
            end
            if (state_nxt == HOST_ACC) begin
                mem_addr_o <= wr_addr_i;
                mem_din_o  <= wr_data_i;
            end
        end
    end

    // Tag line: a granted read reaches the top bit as BRAM data becomes valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_pipe      <= '0;
            disp_valid_o <= 1'b0;
            disp_data_o  <= '0;
        end else begin
            rd_pipe      <= (rd_pipe << 1) | RD_LATENCY'(disp_gnt_o);
            disp_valid_o <= rd_pipe[RD_LATENCY-1];
            if (rd_pipe[RD_LATENCY-1]) begin
                disp_data_o <= mem_dout_i;
            end
        end
    end

endmodule
